// File: rtl/aes_pkg.sv
// Shared types, constants and round helpers for the iterative AES-128 core.
//   word_t  : 32-bit transfer word
//   block_t : 128-bit AES state, FIPS-197 byte order (byte 0 in [127:120];
//             column c holds bytes 4c..4c+3, row r of column c is byte 4c+r)
//   state_e : controller states LOAD / BUSY / DONE
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] NR = 4'd10;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; a0 is the most-significant byte (row 0).
  function automatic word_t mix_column(input word_t col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Row r is rotated left by r columns: out(r,c) = in(r,(c+r) mod 4).
  function automatic block_t shift_rows(input block_t s);
    block_t r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127 - 8 * (4 * c + row) -: 8] = s[127 - 8 * (4 * ((c + row) % 4) + row) -: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational lookup.
//   a : input byte
//   y : substituted byte
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Entry 0 occupies the top byte, so entry n sits at bit offset (255-n)*8.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always_comb begin
    y = SBOX_TABLE[{~a, 3'b000} +: 8];
  end

endmodule

// File: rtl/aes_encrypt.sv
// Iterative AES-128 encryption core, one round per clock with on-the-fly
// key expansion. Key and plaintext are streamed in most-significant word
// first; the ciphertext is streamed out the same way.
//   Clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   keyIn     : key word, taken on load beats 0-3
//   wordIn    : plaintext word, taken on load beats 4-7
//   readFlag  : load-beat enable (one word per edge while high)
//   writeFlag : advance output word index while done
//   done      : ciphertext valid
//   outBuf    : selected ciphertext word, 0 while done is low
// Handshake: a beat transfers on every rising edge where readFlag=1 in
// LOAD (or DONE, which restarts the load); an output word is consumed on
// every rising edge where done=1 and writeFlag=1 and readFlag=0.
module aes_encrypt
  import aes_pkg::*;
(
  input  logic        Clk,
  input  logic        rst,
  input  logic [31:0] keyIn,
  input  logic [31:0] wordIn,
  input  logic        readFlag,
  input  logic        writeFlag,
  output logic        done,
  output logic [31:0] outBuf
);

  state_e     state_q, state_d;
  logic [2:0] beat_q, beat_d;
  logic [3:0] round_q, round_d;
  logic [1:0] idx_q, idx_d;
  block_t     key_q, key_d;
  block_t     text_q, text_d;   // holds plaintext, then AES state, then ciphertext
  block_t     rk_q, rk_d;

  block_t     sub_bytes, sr_out, mc_out, rk_next, round_out;
  word_t      rot_w, sub_w, temp_w;
  logic [7:0] rcon_byte;

  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    aes_sbox u_sbox (.a(text_q[8*i +: 8]), .y(sub_bytes[8*i +: 8]));
  end

  assign rot_w = {rk_q[23:0], rk_q[31:24]};
  for (genvar j = 0; j < 4; j++) begin : g_key_sbox
    aes_sbox u_sbox (.a(rot_w[8*j +: 8]), .y(sub_w[8*j +: 8]));
  end

  // Round key r is built from round key r-1 in the cycle it is consumed.
  always_comb begin
    rcon_byte = (round_q >= 4'd1 && round_q <= NR) ? RCON[round_q] : 8'h00;
    temp_w    = sub_w ^ {rcon_byte, 24'h0};
    rk_next[127:96] = rk_q[127:96] ^ temp_w;
    rk_next[95:64]  = rk_q[95:64]  ^ rk_next[127:96];
    rk_next[63:32]  = rk_q[63:32]  ^ rk_next[95:64];
    rk_next[31:0]   = rk_q[31:0]   ^ rk_next[63:32];
  end

  always_comb begin
    sr_out = shift_rows(sub_bytes);
    mc_out = '0;
    for (int c = 0; c < 4; c++) begin
      mc_out[127 - 32 * c -: 32] = mix_column(sr_out[127 - 32 * c -: 32]);
    end
    round_out = ((round_q == NR) ? sr_out : mc_out) ^ rk_next;
  end

  // State register
  always_ff @(posedge Clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      beat_q  <= '0;
      round_q <= '0;
      idx_q   <= '0;
      key_q   <= '0;
      text_q  <= '0;
      rk_q    <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      round_q <= round_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
      text_q  <= text_d;
      rk_q    <= rk_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: if (readFlag && beat_q == 3'd7) state_d = ST_BUSY;
      ST_BUSY: if (round_q == NR)              state_d = ST_DONE;
      ST_DONE: if (readFlag)                   state_d = ST_LOAD;
      default:                                 state_d = ST_LOAD;
    endcase
  end

  // Datapath and counters
  always_comb begin
    beat_d  = beat_q;
    round_d = round_q;
    idx_d   = idx_q;
    key_d   = key_q;
    text_d  = text_q;
    rk_d    = rk_q;
    case (state_q)
      ST_LOAD: begin
        if (readFlag) begin
          beat_d = beat_q + 3'd1;
          // Word k lives at bit offset (3-k)*32; ~k gives 3-k for 2 bits.
          if (!beat_q[2]) key_d[{~beat_q[1:0], 5'b0} +: 32]  = keyIn;
          else            text_d[{~beat_q[1:0], 5'b0} +: 32] = wordIn;
          if (beat_q == 3'd7) round_d = '0;
        end
      end
      ST_BUSY: begin
        round_d = round_q + 4'd1;
        if (round_q == 4'd0) begin
          text_d = text_q ^ key_q;
          rk_d   = key_q;
        end else begin
          text_d = round_out;
          rk_d   = rk_next;
        end
        if (round_q == NR) idx_d = '0;
      end
      ST_DONE: begin
        // A new load beat takes priority over output advance.
        if (readFlag) begin
          key_d[127:96] = keyIn;
          beat_d        = 3'd1;
          idx_d         = '0;
        end else if (writeFlag) begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: begin
        beat_d  = '0;
        round_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    done   = (state_q == ST_DONE);
    outBuf = done ? text_q[{~idx_q, 5'b0} +: 32] : 32'h0;
  end

endmodule

// File: tb/tb_aes_encrypt.sv
module tb_aes_encrypt;

  logic        Clk = 1'b0;
  logic        rst;
  logic [31:0] keyIn;
  logic [31:0] wordIn;
  logic        readFlag;
  logic        writeFlag;
  logic        done;
  logic [31:0] outBuf;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] TXT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] TXT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_encrypt dut (
    .Clk(Clk), .rst(rst), .keyIn(keyIn), .wordIn(wordIn),
    .readFlag(readFlag), .writeFlag(writeFlag), .done(done), .outBuf(outBuf)
  );

  // Clock / reset
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] word_of(input logic [127:0] b, input int i);
    return b[127 - 32 * i -: 32];
  endfunction

  // Driver: beats first_beat..7, with an optional readFlag gap after beats 2 and 5.
  task automatic load_block(input logic [127:0] k, input logic [127:0] t,
                            input int gap, input int first_beat);
    for (int b = first_beat; b < 8; b++) begin
      readFlag = 1'b1;
      keyIn    = (b < 4) ? word_of(k, b) : 32'hdeadbeef;
      wordIn   = (b >= 4) ? word_of(t, b - 4) : 32'hcafef00d;
      step();
      readFlag = 1'b0;
      if ((b == 2 || b == 5) && gap > 0) repeat (gap) step();
    end
  endtask

  // Counts edges after the last beat until done rises (bounded).
  task automatic wait_done(output int cnt, input bit toggle);
    cnt = 0;
    while (done !== 1'b1 && cnt < 30) begin
      if (toggle) begin
        readFlag  = 1'($urandom_range(0, 1));
        writeFlag = 1'($urandom_range(0, 1));
      end
      step();
      cnt++;
    end
    readFlag  = 1'b0;
    writeFlag = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    readFlag = 1'b0; writeFlag = 1'b0; keyIn = '0; wordIn = '0;
    step(); step();
    rst = 1'b0;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++;
    if (outBuf !== 32'h0) begin errors++; $display("FAIL reset_outbuf: got %h want 0", outBuf); end
  endtask

  task automatic test_fips_b();
    int cnt;
    load_block(KEY_B, TXT_B, 0, 0);
    wait_done(cnt, 1'b0);
    checks++;
    if (cnt !== 11) begin errors++; $display("FAIL b_latency: got %0d edges want 11", cnt); end
    writeFlag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (outBuf !== word_of(CT_B, i % 4)) begin
        errors++; $display("FAIL b_word%0d: got %h want %h", i, outBuf, word_of(CT_B, i % 4));
      end
      step();
    end
    writeFlag = 1'b0;
  endtask

  task automatic test_fips_c1();
    int cnt;
    load_block(KEY_C, TXT_C, 0, 0);
    wait_done(cnt, 1'b0);
    checks++;
    if (cnt !== 11) begin errors++; $display("FAIL c1_latency: got %0d edges want 11", cnt); end
    step(); step();
    checks++;
    if (outBuf !== word_of(CT_C, 0) || done !== 1'b1) begin
      errors++; $display("FAIL c1_hold: got %h/%b want %h/1", outBuf, done, word_of(CT_C, 0));
    end
    writeFlag = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outBuf !== word_of(CT_C, i)) begin
        errors++; $display("FAIL c1_word%0d: got %h want %h", i, outBuf, word_of(CT_C, i));
      end
      step();
    end
    writeFlag = 1'b0;
  endtask

  task automatic test_gaps();
    int cnt;
    load_block(KEY_B, TXT_B, 3, 0);
    wait_done(cnt, 1'b0);
    checks++;
    if (cnt !== 11) begin errors++; $display("FAIL gap_latency: got %0d edges want 11", cnt); end
    writeFlag = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outBuf !== word_of(CT_B, i)) begin
        errors++; $display("FAIL gap_word%0d: got %h want %h", i, outBuf, word_of(CT_B, i));
      end
      step();
    end
    writeFlag = 1'b0;
  endtask

  task automatic test_mid_reset();
    int cnt;
    load_block(KEY_B, TXT_B, 0, 0);
    repeat (6) step();   // round 5 is computed on the sixth edge
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (done !== 1'b0 || outBuf !== 32'h0) begin
      errors++; $display("FAIL midrst_out: got %b/%h want 0/0", done, outBuf);
    end
    load_block(KEY_C, TXT_C, 0, 0);
    wait_done(cnt, 1'b0);
    checks++;
    if (cnt !== 11) begin errors++; $display("FAIL midrst_latency: got %0d edges want 11", cnt); end
    writeFlag = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outBuf !== word_of(CT_C, i)) begin
        errors++; $display("FAIL midrst_word%0d: got %h want %h", i, outBuf, word_of(CT_C, i));
      end
      step();
    end
    step();   // index now at 1, so the reload below must reset it
    writeFlag = 1'b0;
  endtask

  task automatic test_reload_from_done();
    int cnt;
    readFlag  = 1'b1;
    writeFlag = 1'b1;
    keyIn     = word_of(KEY_C, 0);
    step();
    readFlag  = 1'b0;
    writeFlag = 1'b0;
    checks++;
    if (done !== 1'b0 || outBuf !== 32'h0) begin
      errors++; $display("FAIL reload_drop: got %b/%h want 0/0", done, outBuf);
    end
    load_block(KEY_C, TXT_C, 0, 1);
    wait_done(cnt, 1'b0);
    checks++;
    if (cnt !== 11) begin errors++; $display("FAIL reload_latency: got %0d edges want 11", cnt); end
    writeFlag = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outBuf !== word_of(CT_C, i)) begin
        errors++; $display("FAIL reload_word%0d: got %h want %h", i, outBuf, word_of(CT_C, i));
      end
      step();
    end
    writeFlag = 1'b0;
  endtask

  task automatic test_busy_ignore_zero();
    int cnt;
    load_block(128'h0, 128'h0, 0, 0);
    wait_done(cnt, 1'b1);
    checks++;
    if (cnt !== 11) begin errors++; $display("FAIL busy_latency: got %0d edges want 11", cnt); end
    writeFlag = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outBuf !== word_of(CT_Z, i)) begin
        errors++; $display("FAIL zero_word%0d: got %h want %h", i, outBuf, word_of(CT_Z, i));
      end
      step();
    end
    writeFlag = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fips_b();
    test_fips_c1();
    test_gaps();
    test_mid_reset();
    test_reload_from_done();
    test_busy_ignore_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
